// File: rtl/dmux_nway_reg.sv
// dmux_nway_reg: registered N-way demultiplexer with valid/ready handshake.
// Each output channel has a one-entry holding register (EMPTY/FULL). A word
// is steered to the channel named by in_sel, or to every channel when
// in_bcast is set. Unicast words addressed past the last channel are
// accepted and discarded, and they are counted in a saturating drop counter.
module dmux_nway_reg #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 8,
    parameter int SEL_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [WAYS-1:0]         out_valid,
    input  logic [WAYS-1:0]         out_ready,
    output logic [WAYS*WIDTH-1:0]   out_data,
    output logic [15:0]             drop_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    localparam logic [SEL_W:0] WAYS_L = (SEL_W+1)'(WAYS);

    chan_state_t      state_q [WAYS];
    chan_state_t      state_d [WAYS];
    logic [WIDTH-1:0] data_p0 [WAYS];

    logic [WAYS-1:0]  free;
    logic [WAYS-1:0]  sel_hit;
    logic [WAYS-1:0]  load;
    logic             sel_in_range;
    logic             accept;
    logic             drop;

    // Saturating increment: the drop counter sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Handshake decode, per-channel next state and register-driven outputs.
    always_comb begin
        free         = '0;
        sel_hit      = '0;
        load         = '0;
        in_ready     = 1'b0;
        out_valid    = '0;
        out_data     = '0;
        sel_in_range = ({1'b0, in_sel} < WAYS_L);

        for (int k = 0; k < WAYS; k++) begin
            // A draining channel can be refilled in the same cycle.
            free[k]    = (state_q[k] == EMPTY) | out_ready[k];
            sel_hit[k] = (in_sel == SEL_W'(k));
        end

        if (in_bcast)
            in_ready = &free;
        else if (sel_in_range)
            in_ready = |(free & sel_hit);
        else
            in_ready = 1'b1;

        accept = in_valid & in_ready;
        drop   = accept & ~in_bcast & ~sel_in_range;

        if (accept)
            load = in_bcast ? {WAYS{1'b1}} : sel_hit;

        for (int k = 0; k < WAYS; k++) begin
            state_d[k] = state_q[k];
            if (load[k])
                state_d[k] = FULL;
            else if (out_ready[k])
                state_d[k] = EMPTY;

            out_valid[k]                = (state_q[k] == FULL);
            out_data[k*WIDTH +: WIDTH]  = data_p0[k];
        end
    end

    // Channel state and holding registers; reset clears both immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WAYS; k++) begin
                state_q[k] <= EMPTY;
                data_p0[k] <= '0;
            end
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                state_q[k] <= state_d[k];
                if (load[k])
                    data_p0[k] <= in_data;
            end
        end
    end

    // Count unicast words discarded for an out-of-range channel index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count <= 16'd0;
        else if (drop)
            drop_count <= sat_inc(drop_count);
    end

endmodule

// File: doc/dmux_nway_reg.md
# dmux_nway_reg

Registered, parametrised N-way demultiplexer with a valid/ready handshake and a one-entry holding register per output channel. It generalises the fixed 1-bit, 8-way combinational demultiplexer to WIDTH-bit data, WAYS outputs, a broadcast mode and per-channel backpressure. It sits between a single producer (e.g. the CPU store path) and several consumers (memory-mapped devices), steering each accepted word to one channel or to all of them.

## Interface
- WIDTH, 16, data width in bits (>= 1)
- WAYS, 8, number of output channels (2..2**SEL_W)
- SEL_W, 3, select width; WAYS <= 2**SEL_W
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts the word this cycle
- in_data  in  WIDTH  payload
- in_sel  in  SEL_W  destination channel index
- in_bcast  in  1  1 = deliver to all WAYS channels, in_sel ignored
- out_valid  out  WAYS  bit k: channel k holds a word
- out_ready  in  WAYS  bit k: consumer k takes the word this cycle
- out_data  out  WAYS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- drop_count  out  16  words discarded due to out-of-range in_sel, saturating

## Operation
- Per channel k, a two-state machine: EMPTY (out_valid[k]=0) / FULL (out_valid[k]=1), with data register D[k].
- free[k] = EMPTY[k] | out_ready[k] (draining this cycle frees the slot).
- Accept = in_valid & in_ready. in_ready is combinational:
  - in_bcast=1: AND of free[k] over all k.
  - in_bcast=0, in_sel < WAYS: free[in_sel].
  - in_bcast=0, in_sel >= WAYS: 1 (word is dropped).
- On accept, unicast in range: D[in_sel] <= in_data, channel in_sel -> FULL.
- On accept, broadcast: every D[k] <= in_data, every channel -> FULL.
- On accept, out-of-range unicast: no channel changes; drop_count += 1, holds at 16'hFFFF.
- Channel k FULL with out_ready[k]=1 and not loaded this cycle -> EMPTY.
- Channel k FULL, out_ready[k]=1 and loaded same cycle -> stays FULL with new data (no bubble).
- Channel k FULL, out_ready[k]=0: D[k] and out_valid[k] hold; unrelated channels continue independently.
- out_ready[k] while EMPTY: ignored.
- in_data/in_sel/in_bcast are don't-care when in_valid=0; no state changes.
- Never deliver a word to a channel other than the addressed one; never duplicate a unicast word.

## Timing
- Reset (rst_n=0, asynchronous): all channels EMPTY, out_valid=0, out_data=0, drop_count=0. in_ready then follows its combinational rule (1 for any in-range unicast).
- Reset asserted mid-operation: held words are discarded immediately, without waiting for clk; deassertion is synchronous to clk by the upstream reset synchroniser.
- Latency: word accepted at edge N is visible on out_valid/out_data after edge N; the consumer can take it at edge N+1.
- Throughput: one word per cycle per channel when the consumer holds out_ready=1.
- Combinational paths: out_ready -> in_ready and in_sel/in_bcast -> in_ready. out_valid and out_data are register outputs only.
- Broadcast is all-or-nothing: with any channel full and not draining, in_ready=0 and no channel is written.

## Test plan
- Reset/idle: rst_n=0 with in_valid=1 and sel=3 -> out_valid=8'h00, drop_count=0, no load; release and idle 5 cycles -> outputs unchanged.
- Unicast sweep: out_ready=8'hFF, send in_data=16'hA000+k, sel=k for k=0..7 on consecutive cycles -> exactly one out_valid bit set each cycle after the edge, channel k data = 16'hA000+k, in_ready constantly 1.
- Backpressure: out_ready[2]=0, send 16'h1111 then 16'h2222 to sel=2 -> first accepted, second held (in_ready=0) until out_ready[2]=1; next edge channel 2 = 16'h2222 with no gap, and 16'h1111 is consumed exactly once.
- Broadcast: all channels empty, in_bcast=1, in_data=16'hBEEF -> out_valid=8'hFF, every slice = 16'hBEEF; repeat with channel 5 full and out_ready[5]=0 -> in_ready=0, no channel changes.
- Out-of-range drop (WAYS=6, SEL_W=3): send sel=6 then sel=7 -> in_ready=1, out_valid unchanged, drop_count=2; force drop_count near 16'hFFFF via 65537 drops -> it saturates at 16'hFFFF.
- Async reset mid-stream: channels 0 and 3 full, pull rst_n low between edges -> out_valid=0 and drop_count=0 before the next clk edge.
